pmem_arbiter: RTL and testbench

//  Shares the single physical-memory (cacheline) port between I-cache and D-cache miss traffic.

---
 rtl/pmem_arbiter_pkg.sv | 13 +
 rtl/pmem_arbiter_if.sv | 43 ++++
 rtl/pmem_arbiter_perf_counters.sv | 37 +++
 rtl/pmem_arbiter.sv | 130 +++++++++++++
 tb/tb_pmem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the I/D-cache physical-memory arbiter.
package pmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_RD   = 2'd2,
        D_WR   = 2'd3
    } pmem_arb_state_t;

    localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Cacheline bus bundle between I-cache, D-cache, arbiter and the cacheline adapter.
interface pmem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_addr;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;

    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_addr;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Environment side: both caches plus the adapter.
    modport master (
        output icache_pmem_read, icache_pmem_addr,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_addr, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  icache_pmem_read, icache_pmem_addr,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_addr, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_arbiter_perf_counters.sv
// Grant and I-side wait counters for the pmem arbiter (used when PMEM_ARB_PERF_EN is defined).
module arb_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_grant_i,
    input  logic        d_grant_i,
    input  logic        i_wait_i,
    output logic [31:0] perf_i_grants_o,
    output logic [31:0] perf_d_grants_o,
    output logic [31:0] perf_i_wait_o
);
    logic [31:0] i_grants_q, i_grants_d;
    logic [31:0] d_grants_q, d_grants_d;
    logic [31:0] i_wait_q,   i_wait_d;

    always_comb begin
        i_grants_d = i_grants_q + 32'(i_grant_i);
        d_grants_d = d_grants_q + 32'(d_grant_i);
        i_wait_d   = i_wait_q   + 32'(i_wait_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grants_q <= '0;
            d_grants_q <= '0;
            i_wait_q   <= '0;
        end else begin
            i_grants_q <= i_grants_d;
            d_grants_q <= d_grants_d;
            i_wait_q   <= i_wait_d;
        end
    end

    assign perf_i_grants_o = i_grants_q;
    assign perf_d_grants_o = d_grants_q;
    assign perf_i_wait_o   = i_wait_q;
endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single cacheline port between I-cache and D-cache misses; D wins unless I is starving.
// Optional performance counters are enabled by defining PMEM_ARB_PERF_EN.
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate on sampled requests
//   I_BUSY | I-cache fill in flight on the adapter
//   D_RD   | D-cache fill in flight on the adapter
//   D_WR   | D-cache writeback in flight on the adapter
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int LINE_W     = 256,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           rst_n,
    pmem_arbiter_if.slave bus
`ifdef PMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_i_grants_o,
    output logic [31:0]   perf_d_grants_o,
    output logic [31:0]   perf_i_wait_o
`endif
);
    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_I_BUSY = 2'(I_BUSY);
    localparam logic [1:0] ST_D_RD   = 2'(D_RD);
    localparam logic [1:0] ST_D_WR   = 2'(D_WR);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << LINE_OFFSET_W) - 1);

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic i_req, d_req, i_grant, d_grant;

    assign i_req = bus.icache_pmem_read;
    assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        i_grant  = 1'b0;
        d_grant  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // starve_q only grows while I is waiting, so it tops out at STARVE_LIM
                if (d_req && (!i_req || starve_q < STARVE_LIM)) begin
                    d_grant = 1'b1;
                    if (i_req) starve_d = starve_q + 1'b1;
                end else if (i_req) begin
                    i_grant  = 1'b1;
                    starve_d = '0;
                end
                if (d_grant) begin
                    state_d = bus.dcache_pmem_write ? ST_D_WR : ST_D_RD;
                    addr_d  = bus.dcache_pmem_addr & ADDR_MASK;
                    if (bus.dcache_pmem_write) wdata_d = bus.dcache_pmem_wdata;
                end
                if (i_grant) begin
                    state_d = ST_I_BUSY;
                    addr_d  = bus.icache_pmem_addr & ADDR_MASK;
                end
            end
            default: begin
                if (bus.pmem_resp) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.pmem_read  = (state_q == ST_I_BUSY) || (state_q == ST_D_RD);
    assign bus.pmem_write = (state_q == ST_D_WR);
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q;

    // A response that arrives in IDLE belongs to no one and is dropped here.
    assign bus.icache_pmem_resp  = (state_q == ST_I_BUSY) && bus.pmem_resp;
    assign bus.dcache_pmem_resp  = ((state_q == ST_D_RD) || (state_q == ST_D_WR)) && bus.pmem_resp;
    assign bus.icache_pmem_rdata = bus.icache_pmem_resp ? bus.pmem_rdata : '0;
    assign bus.dcache_pmem_rdata = ((state_q == ST_D_RD) && bus.pmem_resp) ? bus.pmem_rdata : '0;

`ifdef PMEM_ARB_PERF_EN
    arb_perf_counters u_perf (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_grant_i       (i_grant),
        .d_grant_i       (d_grant),
        .i_wait_i        (i_req && (state_q != ST_I_BUSY)),
        .perf_i_grants_o (perf_i_grants_o),
        .perf_d_grants_o (perf_d_grants_o),
        .perf_i_wait_o   (perf_i_wait_o)
    );
`endif

`ifndef SYNTHESIS
    a_i_held: assert property (@(posedge clk) disable iff (!rst_n)
        bus.icache_pmem_read && !bus.icache_pmem_resp |=> bus.icache_pmem_read);
    a_i_addr: assert property (@(posedge clk) disable iff (!rst_n)
        bus.icache_pmem_read && !bus.icache_pmem_resp |=> $stable(bus.icache_pmem_addr));
    a_d_rd_held: assert property (@(posedge clk) disable iff (!rst_n)
        bus.dcache_pmem_read && !bus.dcache_pmem_resp |=> bus.dcache_pmem_read);
    a_d_wr_held: assert property (@(posedge clk) disable iff (!rst_n)
        bus.dcache_pmem_write && !bus.dcache_pmem_resp |=> bus.dcache_pmem_write);
    a_d_addr: assert property (@(posedge clk) disable iff (!rst_n)
        d_req && !bus.dcache_pmem_resp |=> $stable(bus.dcache_pmem_addr));
    a_d_wdata: assert property (@(posedge clk) disable iff (!rst_n)
        bus.dcache_pmem_write && !bus.dcache_pmem_resp |=> $stable(bus.dcache_pmem_wdata));
`endif
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed vector table, starvation/reset sequences, randomized run vs model.
`timescale 1ns/1ps
module tb_pmem_arbiter;
    localparam int LINE_W     = 256;
    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 4;
    typedef logic [LINE_W-1:0] w_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

`ifdef PMEM_ARB_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_i_wait;
`endif

    pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PMEM_ARB_PERF_EN
        ,
        .perf_i_grants_o (perf_i_grants),
        .perf_d_grants_o (perf_d_grants),
        .perf_i_wait_o   (perf_i_wait)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input w_t act, input w_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic w_t mkline(input logic [31:0] s);
        return {8{s}};
    endfunction

    task automatic drive_idle();
        bus.icache_pmem_read  = 1'b0;
        bus.icache_pmem_addr  = '0;
        bus.dcache_pmem_read  = 1'b0;
        bus.dcache_pmem_write = 1'b0;
        bus.dcache_pmem_addr  = '0;
        bus.dcache_pmem_wdata = '0;
        bus.pmem_resp         = 1'b0;
        bus.pmem_rdata        = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        i_rd;
        logic [31:0] i_addr;
        logic        d_rd, d_wr;
        logic [31:0] d_addr, wseed;
        logic        resp;
        logic        e_rd, e_wr;
        logic [31:0] e_addr;
        logic        e_iresp, e_dresp, e_drdv;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic i_rd, input logic [31:0] i_addr,
                               input logic d_rd, input logic d_wr,
                               input logic [31:0] d_addr, input logic [31:0] wseed,
                               input logic resp, input logic e_rd, input logic e_wr,
                               input logic [31:0] e_addr, input logic e_iresp,
                               input logic e_dresp, input logic e_drdv);
        vec_t r;
        r.i_rd = i_rd; r.i_addr = i_addr; r.d_rd = d_rd; r.d_wr = d_wr;
        r.d_addr = d_addr; r.wseed = wseed; r.resp = resp;
        r.e_rd = e_rd; r.e_wr = e_wr; r.e_addr = e_addr;
        r.e_iresp = e_iresp; r.e_dresp = e_dresp; r.e_drdv = e_drdv;
        return r;
    endfunction

    task automatic run_table();
        logic [31:0] ws1, ws2;
        ws1 = 32'hDEAD_BEEF;
        ws2 = 32'h1234_5678;
        // lone I read, low address bits must be dropped
        vt.push_back(v(1, 32'h4F, 0, 0, 0, 0, 0,   0, 0, 32'h0,   0, 0, 0));
        vt.push_back(v(1, 32'h4F, 0, 0, 0, 0, 0,   1, 0, 32'h40,  0, 0, 0));
        vt.push_back(v(1, 32'h4F, 0, 0, 0, 0, 0,   1, 0, 32'h40,  0, 0, 0));
        vt.push_back(v(1, 32'h4F, 0, 0, 0, 0, 1,   1, 0, 32'h40,  1, 0, 0));
        vt.push_back(v(0, 0,      0, 0, 0, 0, 0,   0, 0, 32'h40,  0, 0, 0));
        // simultaneous I read and D write: D first, then bubble, then I
        vt.push_back(v(1, 32'h100, 0, 1, 32'h200, ws1, 0, 0, 0, 32'h40,  0, 0, 0));
        vt.push_back(v(1, 32'h100, 0, 1, 32'h200, ws1, 0, 0, 1, 32'h200, 0, 0, 0));
        vt.push_back(v(1, 32'h100, 0, 1, 32'h200, ws1, 1, 0, 1, 32'h200, 0, 1, 0));
        vt.push_back(v(1, 32'h100, 0, 0, 0, 0, 0,         0, 0, 32'h200, 0, 0, 0));
        vt.push_back(v(1, 32'h100, 0, 0, 0, 0, 0,         1, 0, 32'h100, 0, 0, 0));
        vt.push_back(v(1, 32'h100, 0, 0, 0, 0, 1,         1, 0, 32'h100, 1, 0, 0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0,               0, 0, 32'h100, 0, 0, 0));
        // D read and write together: writeback first, fill next
        vt.push_back(v(0, 0, 1, 1, 32'h300, ws2, 0, 0, 0, 32'h100, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h300, ws2, 0, 0, 1, 32'h300, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h300, ws2, 1, 0, 1, 32'h300, 0, 1, 0));
        vt.push_back(v(0, 0, 1, 0, 32'h300, 0, 0,   0, 0, 32'h300, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 0, 32'h300, 0, 0,   1, 0, 32'h300, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 0, 32'h300, 0, 1,   1, 0, 32'h300, 0, 1, 1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0,         0, 0, 32'h300, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            bus.icache_pmem_read  = vt[i].i_rd;
            bus.icache_pmem_addr  = vt[i].i_addr;
            bus.dcache_pmem_read  = vt[i].d_rd;
            bus.dcache_pmem_write = vt[i].d_wr;
            bus.dcache_pmem_addr  = vt[i].d_addr;
            bus.dcache_pmem_wdata = mkline(vt[i].wseed);
            bus.pmem_resp         = vt[i].resp;
            bus.pmem_rdata        = mkline(32'h1000_0000 + 32'(i));
            @(negedge clk);
            chk($sformatf("vec%0d_read", i),  w_t'(bus.pmem_read),  w_t'(vt[i].e_rd));
            chk($sformatf("vec%0d_write", i), w_t'(bus.pmem_write), w_t'(vt[i].e_wr));
            chk($sformatf("vec%0d_addr", i),  w_t'(bus.pmem_addr),  w_t'(vt[i].e_addr));
            chk($sformatf("vec%0d_iresp", i), w_t'(bus.icache_pmem_resp), w_t'(vt[i].e_iresp));
            chk($sformatf("vec%0d_dresp", i), w_t'(bus.dcache_pmem_resp), w_t'(vt[i].e_dresp));
            chk($sformatf("vec%0d_irdata", i), bus.icache_pmem_rdata,
                vt[i].e_iresp ? mkline(32'h1000_0000 + 32'(i)) : w_t'(0));
            chk($sformatf("vec%0d_drdata", i), bus.dcache_pmem_rdata,
                vt[i].e_drdv ? mkline(32'h1000_0000 + 32'(i)) : w_t'(0));
            if (vt[i].e_wr)
                chk($sformatf("vec%0d_wdata", i), bus.pmem_wdata, mkline(vt[i].wseed));
        end
    endtask

    // D keeps reading back-to-back while I holds its request; I must win every fifth grant.
    task automatic run_starve();
        string exp_seq;
        byte   g[$];
        int    sc;
        logic  prev, cur;
        exp_seq = "DDDDIDDDDI";
        sc = 0;
        prev = 1'b0;
        do_reset();
        @(posedge clk); #1;
        bus.icache_pmem_read = 1'b1; bus.icache_pmem_addr = 32'h500;
        bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_addr = 32'h600;
        for (int c = 0; c < 300 && g.size() < 10; c++) begin
            @(negedge clk);
            cur = bus.pmem_read | bus.pmem_write;
            if (cur && !prev) g.push_back(bus.pmem_addr == 32'h500 ? "I" : "D");
            if (cur && !bus.pmem_resp) sc++;
            else sc = 0;
            prev = cur;
            @(posedge clk); #1;
            bus.pmem_resp = (sc >= 2);
        end
        chk("starve_grant_count", w_t'(g.size()), w_t'(10));
        for (int k = 0; k < g.size(); k++)
            chk($sformatf("starve_grant%0d", k), w_t'(g[k]), w_t'(exp_seq[k]));
        do_reset();
    endtask

    task automatic run_reset_mid();
        @(posedge clk); #1;
        bus.icache_pmem_read = 1'b1; bus.icache_pmem_addr = 32'h713;
        @(negedge clk);
        chk("rst_pre_grant_read", w_t'(bus.pmem_read), w_t'(0));
        @(negedge clk);
        chk("rst_busy_read", w_t'(bus.pmem_read), w_t'(1));
        #2;
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = mkline(32'hBAD0_BAD0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_read",  w_t'(bus.pmem_read),  w_t'(0));
        chk("rst_async_write", w_t'(bus.pmem_write), w_t'(0));
        chk("rst_async_iresp", w_t'(bus.icache_pmem_resp), w_t'(0));
        chk("rst_async_irdata", bus.icache_pmem_rdata, w_t'(0));
        chk("rst_async_addr",  w_t'(bus.pmem_addr),  w_t'(0));
        bus.icache_pmem_read = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("stale_resp_iresp", w_t'(bus.icache_pmem_resp), w_t'(0));
        chk("stale_resp_dresp", w_t'(bus.dcache_pmem_resp), w_t'(0));
        chk("stale_resp_read",  w_t'(bus.pmem_read), w_t'(0));
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        bus.icache_pmem_read = 1'b1; bus.icache_pmem_addr = 32'h740;
        @(negedge clk);
        chk("reissue_idle_read", w_t'(bus.pmem_read), w_t'(0));
        @(negedge clk);
        chk("reissue_read", w_t'(bus.pmem_read), w_t'(1));
        chk("reissue_addr", w_t'(bus.pmem_addr), w_t'(32'h740));
        @(posedge clk); #1;
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = mkline(32'h7777_0001);
        @(negedge clk);
        chk("reissue_iresp", w_t'(bus.icache_pmem_resp), w_t'(1));
        chk("reissue_irdata", bus.icache_pmem_rdata, mkline(32'h7777_0001));
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("reissue_done_read", w_t'(bus.pmem_read), w_t'(0));
    endtask

`ifdef PMEM_ARB_PERF_EN
    task automatic run_perf();
        do_reset();
        @(posedge clk); #1;
        bus.icache_pmem_read = 1'b1; bus.icache_pmem_addr = 32'h100;
        bus.dcache_pmem_write = 1'b1; bus.dcache_pmem_addr = 32'h200;
        bus.dcache_pmem_wdata = mkline(32'hCAFE_0001);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            bus.pmem_resp = (j == 4);
        end
        @(negedge clk);
        chk("perf_d_resp", w_t'(bus.dcache_pmem_resp), w_t'(1));
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        bus.dcache_pmem_write = 1'b0;
        @(posedge clk); #1;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        chk("perf_i_resp", w_t'(bus.icache_pmem_resp), w_t'(1));
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("perf_d_grants", w_t'(perf_d_grants), w_t'(1));
        chk("perf_i_grants", w_t'(perf_i_grants), w_t'(1));
        chk("perf_i_wait",   w_t'(perf_i_wait),   w_t'(7));
    endtask
`endif

    // Reference: owner 0 none, 1 I fill, 2 D fill, 3 D writeback.
    task automatic run_random(input int cycles);
        int          m_owner, m_starve, a_cnt, a_lat, kind;
        logic [31:0] m_addr;
        w_t          m_wdata;
        logic        ti_rd, td_rd, td_wr, e_ir, e_dr, d_wants, i_wins;
        logic [31:0] ti_addr, td_addr;
        w_t          td_wd, rline;
        do_reset();
        m_owner = 0; m_starve = 0; m_addr = '0; m_wdata = '0;
        a_cnt = 0; a_lat = 1;
        ti_rd = 0; td_rd = 0; td_wr = 0; ti_addr = '0; td_addr = '0; td_wd = '0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (!ti_rd && $urandom_range(3) == 0) begin
                ti_rd = 1'b1; ti_addr = $urandom;
            end
            if (!td_rd && !td_wr && $urandom_range(2) == 0) begin
                kind = int'($urandom_range(2));
                td_rd = (kind != 1); td_wr = (kind != 0);
                td_addr = $urandom;
                for (int w = 0; w < 8; w++) td_wd[w*32 +: 32] = $urandom;
            end
            if (m_owner != 0) begin
                a_cnt++;
                bus.pmem_resp = (a_cnt >= a_lat);
                if (a_cnt >= a_lat) begin
                    a_cnt = 0; a_lat = 1 + int'($urandom_range(3));
                end
            end else begin
                a_cnt = 0;
                bus.pmem_resp = ($urandom_range(7) == 0);
            end
            for (int w = 0; w < 8; w++) rline[w*32 +: 32] = $urandom;
            bus.pmem_rdata        = rline;
            bus.icache_pmem_read  = ti_rd;
            bus.icache_pmem_addr  = ti_addr;
            bus.dcache_pmem_read  = td_rd;
            bus.dcache_pmem_write = td_wr;
            bus.dcache_pmem_addr  = td_addr;
            bus.dcache_pmem_wdata = td_wd;
            @(negedge clk);
            e_ir = (m_owner == 1) && bus.pmem_resp;
            e_dr = (m_owner >= 2) && bus.pmem_resp;
            chk("rnd_read",  w_t'(bus.pmem_read),  w_t'(m_owner == 1 || m_owner == 2));
            chk("rnd_write", w_t'(bus.pmem_write), w_t'(m_owner == 3));
            chk("rnd_addr",  w_t'(bus.pmem_addr),  w_t'(m_addr));
            chk("rnd_iresp", w_t'(bus.icache_pmem_resp), w_t'(e_ir));
            chk("rnd_dresp", w_t'(bus.dcache_pmem_resp), w_t'(e_dr));
            chk("rnd_irdata", bus.icache_pmem_rdata, e_ir ? rline : w_t'(0));
            chk("rnd_drdata", bus.dcache_pmem_rdata, (e_dr && m_owner == 2) ? rline : w_t'(0));
            if (m_owner == 3) chk("rnd_wdata", bus.pmem_wdata, m_wdata);
            if (e_ir) ti_rd = 1'b0;
            if (e_dr) begin
                if (m_owner == 3) td_wr = 1'b0;
                else td_rd = 1'b0;
            end
            if (m_owner == 0) begin
                d_wants = bus.dcache_pmem_read | bus.dcache_pmem_write;
                i_wins  = bus.icache_pmem_read && (!d_wants || m_starve == STARVE_MAX);
                if (i_wins) begin
                    m_owner = 1; m_starve = 0;
                    m_addr = bus.icache_pmem_addr & 32'hFFFF_FFE0;
                end else if (d_wants) begin
                    if (bus.icache_pmem_read) m_starve++;
                    m_owner = bus.dcache_pmem_write ? 3 : 2;
                    m_addr = bus.dcache_pmem_addr & 32'hFFFF_FFE0;
                    if (bus.dcache_pmem_write) m_wdata = bus.dcache_pmem_wdata;
                end
            end else if (bus.pmem_resp) begin
                m_owner = 0;
            end
        end
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        #3;
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = mkline(32'h5555_AAAA);
        #1;
        chk("reset_read",   w_t'(bus.pmem_read),  w_t'(0));
        chk("reset_write",  w_t'(bus.pmem_write), w_t'(0));
        chk("reset_addr",   w_t'(bus.pmem_addr),  w_t'(0));
        chk("reset_wdata",  bus.pmem_wdata, w_t'(0));
        chk("reset_iresp",  w_t'(bus.icache_pmem_resp), w_t'(0));
        chk("reset_dresp",  w_t'(bus.dcache_pmem_resp), w_t'(0));
        chk("reset_irdata", bus.icache_pmem_rdata, w_t'(0));
        chk("reset_drdata", bus.dcache_pmem_rdata, w_t'(0));
        drive_idle();
        #8;
        rst_n = 1'b1;
        run_table();
        run_starve();
        run_reset_mid();
`ifdef PMEM_ARB_PERF_EN
        run_perf();
`endif
        run_random(3000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule
